// File: rtl/alu_flags_unit_pkg.sv
// Shared definitions for the ALU flag unit: flag layout, operation classes,
// condition codes and the branch-condition evaluator.
package alu_flags_unit_pkg;

  localparam int unsigned FLAG_W = 4;

  localparam int unsigned FLAG_O = 3;
  localparam int unsigned FLAG_S = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_Z = 0;

  localparam logic [1:0] OPC_LOGIC = 2'b00;
  localparam logic [1:0] OPC_ADD   = 2'b01;
  localparam logic [1:0] OPC_SUB   = 2'b10;
  localparam logic [1:0] OPC_SHIFT = 2'b11;

  localparam logic [3:0] CC_AL = 4'd0;
  localparam logic [3:0] CC_EQ = 4'd1;
  localparam logic [3:0] CC_NE = 4'd2;
  localparam logic [3:0] CC_CS = 4'd3;
  localparam logic [3:0] CC_CC = 4'd4;
  localparam logic [3:0] CC_MI = 4'd5;
  localparam logic [3:0] CC_PL = 4'd6;
  localparam logic [3:0] CC_VS = 4'd7;
  localparam logic [3:0] CC_VC = 4'd8;
  localparam logic [3:0] CC_GE = 4'd9;
  localparam logic [3:0] CC_LT = 4'd10;
  localparam logic [3:0] CC_GT = 4'd11;
  localparam logic [3:0] CC_LE = 4'd12;
  localparam logic [3:0] CC_HI = 4'd13;
  localparam logic [3:0] CC_LS = 4'd14;
  localparam logic [3:0] CC_NV = 4'd15;

  // Bit order matches the external {O,S,C,Z} flag bus.
  typedef struct packed {
    logic o;
    logic s;
    logic c;
    logic z;
  } flags_t;

  function automatic logic eval_cond(input flags_t f, input logic [3:0] cc);
    logic r;
    r = 1'b0;
    case (cc)
      CC_AL:   r = 1'b1;
      CC_EQ:   r = f.z;
      CC_NE:   r = ~f.z;
      CC_CS:   r = f.c;
      CC_CC:   r = ~f.c;
      CC_MI:   r = f.s;
      CC_PL:   r = ~f.s;
      CC_VS:   r = f.o;
      CC_VC:   r = ~f.o;
      CC_GE:   r = (f.s == f.o);
      CC_LT:   r = (f.s != f.o);
      CC_GT:   r = ~f.z & (f.s == f.o);
      CC_LE:   r = f.z | (f.s != f.o);
      CC_HI:   r = f.c & ~f.z;
      CC_LS:   r = ~f.c | f.z;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_flags_unit_flag_stack.sv
// LIFO used to save/restore flag words around interrupts and calls.
// Overflow/underflow attempts leave the stack untouched and raise a sticky error.
module alu_flags_unit_flag_stack #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_top_c,
  output logic             o_pop_ok_c,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_err;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic          w_push_ok;
  logic          w_pop_ok;
  logic          w_bad;
  logic [CW-1:0] w_count_nxt;
  logic [AW-1:0] w_top_idx;

  // Simultaneous push and pop cancel each other without error.
  assign w_push_ok = i_push & ~i_pop & ~r_full;
  assign w_pop_ok  = i_pop & ~i_push & ~r_empty;
  assign w_bad     = (i_push & ~i_pop & r_full) | (i_pop & ~i_push & r_empty);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_pop_ok) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
      r_err   <= r_err | w_bad;
    end
  end

  // Storage needs no reset: entries above the count are never read.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_count[AW-1:0]] <= i_din;
    end
  end

  // When full the low count bits wrap to 0, so minus one still lands on the top entry.
  assign w_top_idx  = r_count[AW-1:0] - AW'(1);
  assign o_top_c    = r_mem[w_top_idx];
  assign o_pop_ok_c = w_pop_ok;
  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_err      = r_err;

endmodule

// File: rtl/alu_flags_unit.sv
// Registered O/S/C/Z flag file with per-flag write mask, save/restore stack
// and branch condition evaluation.
module alu_flags_unit
  import alu_flags_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_res,
  input  logic             i_c_in,
  input  logic [1:0]       i_opclass,
  input  logic             i_we,
  input  logic [3:0]       i_fmask,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [3:0]       i_cond,
  output logic [3:0]       o_flags,
  output logic             o_cond_true,
  output logic             o_stk_full,
  output logic             o_stk_empty,
  output logic             o_stk_err
);

  localparam int unsigned MSB = WIDTH - 1;

  flags_t             r_flags;
  flags_t             w_derived;
  logic [FLAG_W-1:0]  w_flags_nxt;
  logic [FLAG_W-1:0]  w_merged;
  logic [FLAG_W-1:0]  w_top;
  logic               w_pop_ok;
  logic               w_unused;

  // Only the sign bits of the operands matter for overflow detection.
  assign w_unused = ^{i_a[MSB-1:0], i_b[MSB-1:0]};

  alu_flags_unit_flag_stack #(
    .WIDTH (FLAG_W),
    .DEPTH (DEPTH)
  ) u_stack (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (i_push),
    .i_pop      (i_pop),
    .i_din      (r_flags),
    .o_top_c    (w_top),
    .o_pop_ok_c (w_pop_ok),
    .o_full     (o_stk_full),
    .o_empty    (o_stk_empty),
    .o_err      (o_stk_err)
  );

  // Candidate flags from the current ALU result.
  always_comb begin
    w_derived   = '0;
    w_derived.s = i_res[MSB];
    w_derived.z = (i_res == '0);
    case (i_opclass)
      OPC_ADD: begin
        w_derived.o = (i_a[MSB] == i_b[MSB]) & (i_res[MSB] != i_a[MSB]);
        w_derived.c = i_c_in;
      end
      OPC_SUB: begin
        w_derived.o = (i_a[MSB] != i_b[MSB]) & (i_res[MSB] != i_a[MSB]);
        w_derived.c = i_c_in;
      end
      OPC_SHIFT: w_derived.c = i_c_in;
      default: ;
    endcase
  end

  assign w_merged = (r_flags & ~i_fmask) | (w_derived & i_fmask);

  // A pop request, successful or not, always suppresses the write strobe.
  always_comb begin
    w_flags_nxt = r_flags;
    if (w_pop_ok) begin
      w_flags_nxt = w_top;
    end else if (i_we & ~i_pop) begin
      w_flags_nxt = w_merged;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_flags <= '0;
    end else begin
      r_flags <= flags_t'(w_flags_nxt);
    end
  end

  assign o_flags     = r_flags;
  assign o_cond_true = eval_cond(r_flags, i_cond);

endmodule

// File: tb/tb_alu_flags_unit.sv
// Self-checking bench for alu_flags_unit: directed scenarios plus randomized
// traffic compared against an arithmetic reference model.
module tb_alu_flags_unit;

  localparam int unsigned W = 32;
  localparam int unsigned D = 4;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b, res;
  logic         cin;
  logic [1:0]   opc;
  logic         we, push, pop;
  logic [3:0]   fmask, cond;
  logic [3:0]   flags;
  logic         cond_true, full, empty, err;

  int checks = 0;
  int failures = 0;

  logic [3:0] m_flags;
  logic [3:0] m_stk[$];
  logic       m_err;

  alu_flags_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .i_clk(clk), .i_rst(rst), .i_a(a), .i_b(b), .i_res(res), .i_c_in(cin),
    .i_opclass(opc), .i_we(we), .i_fmask(fmask), .i_push(push), .i_pop(pop),
    .i_cond(cond), .o_flags(flags), .o_cond_true(cond_true),
    .o_stk_full(full), .o_stk_empty(empty), .o_stk_err(err)
  );

  always #50 clk = ~clk;

  // Overflow taken from the exact signed result falling outside the W-bit range.
  function automatic logic [3:0] ref_next(input logic [1:0] op, input logic [W-1:0] x,
                                          input logic [W-1:0] y, input logic [W-1:0] r,
                                          input logic ci);
    longint sx, sy, exact;
    logic o, c;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    o = 1'b0;
    c = 1'b0;
    case (op)
      2'd1: begin exact = sx + sy; o = (exact > MAXS) || (exact < MINS); c = ci; end
      2'd2: begin exact = sx - sy; o = (exact > MAXS) || (exact < MINS); c = ci; end
      2'd3: c = ci;
      default: ;
    endcase
    return {o, r[W-1], c, (r == 0)};
  endfunction

  function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] c);
    logic o, s, cy, z;
    {o, s, cy, z} = f;
    case (c)
      4'd0: return 1'b1;
      4'd1: return z;
      4'd2: return !z;
      4'd3: return cy;
      4'd4: return !cy;
      4'd5: return s;
      4'd6: return !s;
      4'd7: return o;
      4'd8: return !o;
      4'd9: return s == o;
      4'd10: return s != o;
      4'd11: return !z && (s == o);
      4'd12: return z || (s != o);
      4'd13: return cy && !z;
      4'd14: return !cy || z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_flags = 4'b0000;
      m_stk.delete();
      m_err = 1'b0;
    end else begin
      if (push && !pop) begin
        if (m_stk.size() == D) m_err = 1'b1;
        else m_stk.push_back(m_flags);
      end
      if (pop && !push) begin
        if (m_stk.size() == 0) m_err = 1'b1;
        else m_flags = m_stk.pop_back();
      end
      if (we && !pop)
        m_flags = (m_flags & ~fmask) | (ref_next(opc, a, b, res, cin) & fmask);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; we = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic set_op(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] r, input logic ci);
    opc = op; a = x; b = y; res = r; cin = ci;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    if (flags !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b want=0000", flags); end
    checks++;
    if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b want=1", empty); end
    checks++;
    if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b want=0", full); end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
    checks++;
  endtask

  task automatic test_add_overflow();
    idle();
    set_op(2'd1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
    we = 1'b1; fmask = 4'hF;
    tick();
    we = 1'b0;
    if (flags !== 4'b1100) begin failures++; $display("FAIL add_ovf_flags got=%b want=1100", flags); end
    checks++;
    cond = 4'd7; #1;
    if (cond_true !== 1'b1) begin failures++; $display("FAIL add_ovf_vs got=%b want=1", cond_true); end
    checks++;
    cond = 4'd10; #1;
    if (cond_true !== 1'b0) begin failures++; $display("FAIL add_ovf_lt got=%b want=0", cond_true); end
    checks++;
  endtask

  task automatic test_sub_masked();
    idle();
    set_op(2'd2, 32'd5, 32'd5, 32'd0, 1'b1);
    we = 1'b1; fmask = 4'b0001;
    tick();
    we = 1'b0;
    if (flags !== 4'b1101) begin failures++; $display("FAIL sub_mask_flags got=%b want=1101", flags); end
    checks++;
    cond = 4'd1; #1;
    if (cond_true !== 1'b1) begin failures++; $display("FAIL sub_mask_eq got=%b want=1", cond_true); end
    checks++;
    cond = 4'd2; #1;
    if (cond_true !== 1'b0) begin failures++; $display("FAIL sub_mask_ne got=%b want=0", cond_true); end
    checks++;
  endtask

  task automatic test_stack_fill_drain();
    logic [3:0] exp_f [4];
    exp_f = '{4'b1100, 4'b0011, 4'b0100, 4'b1000};
    do_reset();
    fmask = 4'hF;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: set_op(2'd1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
        1: set_op(2'd1, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1);
        2: set_op(2'd0, 32'h8000_0001, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1);
        default: set_op(2'd2, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0);
      endcase
      we = 1'b1;
      push = (i != 0);
      tick();
      if (flags !== exp_f[i]) begin failures++; $display("FAIL stk_write%0d got=%b want=%b", i, flags, exp_f[i]); end
      checks++;
    end
    we = 1'b0; push = 1'b1;
    tick();
    if (full !== 1'b1 || err !== 1'b0) begin
      failures++; $display("FAIL stk_full got=%b/%b want=1/0", full, err);
    end
    checks++;
    tick();
    if (full !== 1'b1 || err !== 1'b1 || flags !== 4'b1000) begin
      failures++; $display("FAIL stk_overflow full/err/flags got=%b/%b/%b want=1/1/1000", full, err, flags);
    end
    checks++;
    push = 1'b0; pop = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      tick();
      if (flags !== exp_f[i]) begin failures++; $display("FAIL stk_pop%0d got=%b want=%b", i, flags, exp_f[i]); end
      checks++;
    end
    pop = 1'b0;
    if (empty !== 1'b1 || full !== 1'b0) begin
      failures++; $display("FAIL stk_drained empty/full got=%b/%b want=1/0", empty, full);
    end
    checks++;
  endtask

  task automatic test_pop_with_we();
    do_reset();
    fmask = 4'hF;
    set_op(2'd3, 32'h1, 32'h0, 32'h1, 1'b1);
    we = 1'b1;
    tick();
    we = 1'b0; push = 1'b1;
    tick();
    push = 1'b0;
    set_op(2'd1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b1);
    we = 1'b1;
    tick();
    if (flags !== 4'b1110) begin failures++; $display("FAIL popwe_pre got=%b want=1110", flags); end
    checks++;
    pop = 1'b1;
    tick();
    idle();
    if (flags !== 4'b0010 || empty !== 1'b1 || err !== 1'b0) begin
      failures++; $display("FAIL popwe flags/empty/err got=%b/%b/%b want=0010/1/0", flags, empty, err);
    end
    checks++;
  endtask

  task automatic test_pop_empty();
    do_reset();
    push = 1'b1; pop = 1'b1;
    tick();
    if (err !== 1'b0 || empty !== 1'b1) begin
      failures++; $display("FAIL pushpop_empty err/empty got=%b/%b want=0/1", err, empty);
    end
    checks++;
    push = 1'b0;
    tick();
    pop = 1'b0;
    if (flags !== 4'b0000 || err !== 1'b1) begin
      failures++; $display("FAIL pop_empty flags/err got=%b/%b want=0000/1", flags, err);
    end
    checks++;
    tick();
    if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b want=1", err); end
    checks++;
    do_reset();
    if (err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b want=0", err); end
    checks++;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random(input int n);
    logic [W-1:0] x, y, r;
    logic ci;
    int sh;
    logic [1:0] op;
    for (int i = 0; i < n; i++) begin
      x = pick(); y = pick();
      op = 2'($urandom_range(0, 3));
      case (op)
        2'd1: begin r = x + y; ci = ({1'b0, x} + {1'b0, y}) > {1'b0, 32'hFFFF_FFFF}; end
        2'd2: begin r = x - y; ci = (x < y); end
        2'd3: begin sh = $urandom_range(1, 31); r = x << sh; ci = x[W - sh]; end
        default: begin r = ($urandom_range(0, 1) == 1) ? (x & y) : (x ^ y); ci = $urandom_range(0, 1) == 1; end
      endcase
      set_op(op, x, y, r, ci);
      rst   = ($urandom_range(0, 199) == 0);
      we    = ($urandom_range(0, 1) == 1);
      push  = ($urandom_range(0, 3) == 0);
      pop   = ($urandom_range(0, 3) == 0);
      fmask = 4'($urandom_range(0, 15));
      tick();
      if (flags !== m_flags) begin failures++; $display("FAIL rnd_flags cyc=%0d got=%b want=%b", i, flags, m_flags); end
      checks++;
      if (full !== (m_stk.size() == D) || empty !== (m_stk.size() == 0) || err !== m_err) begin
        failures++;
        $display("FAIL rnd_stack cyc=%0d full/empty/err got=%b/%b/%b want=%b/%b/%b", i, full, empty, err,
                 m_stk.size() == D, m_stk.size() == 0, m_err);
      end
      checks++;
      for (int c = 0; c < 16; c++) begin
        cond = 4'(c);
        #1;
        if (cond_true !== ref_cond(m_flags, cond)) begin
          failures++; $display("FAIL rnd_cond cyc=%0d cc=%0d got=%b want=%b", i, c, cond_true, ref_cond(m_flags, cond));
        end
        checks++;
      end
    end
    idle();
  endtask

  initial begin
    idle();
    set_op(2'd0, '0, '0, '0, 1'b0);
    fmask = 4'h0;
    cond = 4'd0;
    m_flags = 4'b0000;
    m_err = 1'b0;
    #1;
    test_reset();
    test_add_overflow();
    test_sub_masked();
    test_stack_fill_drain();
    test_pop_with_we();
    test_pop_empty();
    test_random(3000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
